// File: rtl/wisc_pkg.sv
// Shared types for the WISC 16-bit core: opcodes, branch conditions and
// the decoded ID/EX control bundle.
package wisc_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_NAND = 4'h2,
      OP_XOR  = 4'h3,
      OP_INC  = 4'h4,
      OP_SRA  = 4'h5,
      OP_SRL  = 4'h6,
      OP_SLL  = 4'h7,
      OP_LW   = 4'h8,
      OP_SW   = 4'h9,
      OP_LHB  = 4'hA,
      OP_LLB  = 4'hB,
      OP_B    = 4'hC,
      OP_CALL = 4'hD,
      OP_RET  = 4'hE,
      OP_HLT  = 4'hF
   } opcode_e;

   localparam logic [2:0] BR_NEQ    = 3'b000;
   localparam logic [2:0] BR_EQ     = 3'b001;
   localparam logic [2:0] BR_GT     = 3'b010;
   localparam logic [2:0] BR_LT     = 3'b011;
   localparam logic [2:0] BR_GTE    = 3'b100;
   localparam logic [2:0] BR_LTE    = 3'b101;
   localparam logic [2:0] BR_OVFL   = 3'b110;
   localparam logic [2:0] BR_UNCOND = 3'b111;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src;
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_we;
      logic [2:0] br_cond;
      logic       branch;
      logic       call;
      logic       ret;
      logic       halt;
   } idex_t;

   // CALL links into the highest-numbered register
   function automatic int link_reg(input int num_regs);
      return num_regs - 1;
   endfunction

   localparam int LINK_REG = 15;

endpackage

// File: rtl/reg_file.sv
// Register file: two asynchronous read ports, one synchronous write port,
// R0 reads as zero and ignores writes.
module reg_file
   import wisc_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NUM_REGS = 16,
   localparam int RA_W = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [RA_W-1:0]   waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [RA_W-1:0]   raddr_a,
   input  logic [RA_W-1:0]   raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs_r [NUM_REGS];

   // register array: cleared on reset, written from writeback
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs_r[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == '0) ? '0 : regs_r[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : regs_r[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// WISC instruction-decode stage: decode, register read with writeback
// bypass, load-use stall, flush/backpressure and the registered ID/EX bundle.
module decode_stage
   import wisc_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NUM_REGS = 16,
   parameter int PC_W = 16,
   localparam int RA_W = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [15:0]       if_instr,
   input  logic [PC_W-1:0]   if_pc,
   output logic              id_ready,
   input  logic              flush,
   input  logic              wb_we,
   input  logic [RA_W-1:0]   wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [PC_W-1:0]   ex_pc,
   output logic [RA_W-1:0]   ex_rd,
   output logic [DATA_W-1:0] ex_op_a,
   output logic [DATA_W-1:0] ex_op_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic [3:0]        ex_alu_op,
   output logic              ex_alu_src,
   output logic              ex_mem_rd,
   output logic              ex_mem_wr,
   output logic              ex_reg_we,
   output logic [2:0]        ex_br_cond,
   output logic              ex_branch,
   output logic              ex_call,
   output logic              ex_ret,
   output logic              ex_halt
);

   localparam logic [RA_W-1:0] LINK = RA_W'(link_reg(NUM_REGS));

   typedef struct packed {
      logic              valid;
      logic [PC_W-1:0]   pc;
      logic [RA_W-1:0]   rd;
      logic [DATA_W-1:0] op_a;
      logic [DATA_W-1:0] op_b;
      logic [DATA_W-1:0] imm;
      idex_t             ctrl;
   } stage_t;

   opcode_e           op_s;
   idex_t             ctrl_s;
   logic [RA_W-1:0]   ra_s, rb_s, rd_s;
   logic              use_a_s, use_b_s;
   logic [DATA_W-1:0] imm_s, rf_a_s, rf_b_s, op_a_s, op_b_s;
   logic              hazard_s, hold_s, accept_s, load_s;
   logic              halted_r;
   stage_t            stage_r, stage_n;

   assign op_s = opcode_e'(if_instr[15:12]);

   // instruction decode: source addresses, destination, immediate, controls
   always_comb begin
      ctrl_s        = '0;
      ctrl_s.alu_op = if_instr[15:12];
      ra_s          = '0;
      rb_s          = '0;
      rd_s          = '0;
      use_a_s       = 1'b0;
      use_b_s       = 1'b0;
      imm_s         = '0;
      case (op_s)
         OP_ADD, OP_SUB, OP_NAND, OP_XOR: begin
            ra_s = RA_W'(if_instr[7:4]);
            rb_s = RA_W'(if_instr[3:0]);
            use_a_s = 1'b1;
            use_b_s = 1'b1;
            rd_s = RA_W'(if_instr[11:8]);
            ctrl_s.reg_we = 1'b1;
         end
         OP_INC, OP_SRA, OP_SRL, OP_SLL: begin
            ra_s = RA_W'(if_instr[7:4]);
            use_a_s = 1'b1;
            imm_s = {{(DATA_W-4){1'b0}}, if_instr[3:0]};
            ctrl_s.alu_src = 1'b1;
            rd_s = RA_W'(if_instr[11:8]);
            ctrl_s.reg_we = 1'b1;
         end
         OP_LW: begin
            ra_s = RA_W'(if_instr[7:4]);
            use_a_s = 1'b1;
            imm_s = {{(DATA_W-4){if_instr[3]}}, if_instr[3:0]};
            ctrl_s.alu_src = 1'b1;
            ctrl_s.mem_rd = 1'b1;
            rd_s = RA_W'(if_instr[11:8]);
            ctrl_s.reg_we = 1'b1;
         end
         OP_SW: begin
            ra_s = RA_W'(if_instr[7:4]);
            rb_s = RA_W'(if_instr[11:8]);
            use_a_s = 1'b1;
            use_b_s = 1'b1;
            imm_s = {{(DATA_W-4){if_instr[3]}}, if_instr[3:0]};
            ctrl_s.alu_src = 1'b1;
            ctrl_s.mem_wr = 1'b1;
         end
         OP_LHB, OP_LLB: begin
            ra_s = RA_W'(if_instr[11:8]);
            use_a_s = 1'b1;
            imm_s = {{(DATA_W-8){1'b0}}, if_instr[7:0]};
            ctrl_s.alu_src = 1'b1;
            rd_s = RA_W'(if_instr[11:8]);
            ctrl_s.reg_we = 1'b1;
         end
         OP_B: begin
            ctrl_s.br_cond = if_instr[11:9];
            imm_s = {{(DATA_W-9){if_instr[8]}}, if_instr[8:0]};
            ctrl_s.branch = 1'b1;
         end
         OP_CALL: begin
            imm_s = {{(DATA_W-12){if_instr[11]}}, if_instr[11:0]};
            ctrl_s.call = 1'b1;
            rd_s = LINK;
            ctrl_s.reg_we = 1'b1;
         end
         OP_RET: begin
            ra_s = LINK;
            use_a_s = 1'b1;
            ctrl_s.ret = 1'b1;
         end
         OP_HLT: begin
            ctrl_s.halt = 1'b1;
         end
         default: begin
            ctrl_s = '0;
         end
      endcase
   end

   reg_file #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_reg_file (
      .clk     (clk),
      .rst     (rst),
      .we      (wb_we),
      .waddr   (wb_addr),
      .wdata   (wb_data),
      .raddr_a (ra_s),
      .raddr_b (rb_s),
      .rdata_a (rf_a_s),
      .rdata_b (rf_b_s)
   );

   // same-cycle writeback wins over the stored value; R0 is never bypassed
   assign op_a_s = (wb_we && (wb_addr == ra_s) && (ra_s != '0)) ? wb_data : rf_a_s;
   assign op_b_s = (wb_we && (wb_addr == rb_s) && (rb_s != '0)) ? wb_data : rf_b_s;

   assign hazard_s = if_valid && stage_r.valid && stage_r.ctrl.mem_rd && (stage_r.rd != '0)
                     && ((use_a_s && (ra_s == stage_r.rd)) || (use_b_s && (rb_s == stage_r.rd)));
   assign hold_s   = stage_r.valid && !ex_ready;
   assign id_ready = !rst && !halted_r && !hazard_s && !hold_s;
   assign accept_s = if_valid && id_ready;
   assign load_s   = accept_s && !flush;

   // next ID/EX contents: flush beats hold, hold beats issue, otherwise bubble
   always_comb begin
      stage_n = stage_r;
      if (load_s) begin
         stage_n.valid = 1'b1;
         stage_n.pc    = if_pc;
         stage_n.rd    = rd_s;
         stage_n.op_a  = op_a_s;
         stage_n.op_b  = op_b_s;
         stage_n.imm   = imm_s;
         stage_n.ctrl  = ctrl_s;
      end else if (flush || !hold_s) begin
         stage_n = '0;
      end else begin
         stage_n = stage_r;
      end
   end

   // ID/EX register and sticky halt flag
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_r  <= '0;
         halted_r <= 1'b0;
      end else begin
         stage_r <= stage_n;
         if (load_s && ctrl_s.halt) begin
            halted_r <= 1'b1;
         end
      end
   end

   assign ex_valid   = stage_r.valid;
   assign ex_pc      = stage_r.pc;
   assign ex_rd      = stage_r.rd;
   assign ex_op_a    = stage_r.op_a;
   assign ex_op_b    = stage_r.op_b;
   assign ex_imm     = stage_r.imm;
   assign ex_alu_op  = stage_r.ctrl.alu_op;
   assign ex_alu_src = stage_r.ctrl.alu_src;
   assign ex_mem_rd  = stage_r.ctrl.mem_rd;
   assign ex_mem_wr  = stage_r.ctrl.mem_wr;
   assign ex_reg_we  = stage_r.ctrl.reg_we;
   assign ex_br_cond = stage_r.ctrl.br_cond;
   assign ex_branch  = stage_r.ctrl.branch;
   assign ex_call    = stage_r.ctrl.call;
   assign ex_ret     = stage_r.ctrl.ret;
   assign ex_halt    = stage_r.ctrl.halt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ID/EX entries are queued on issue
// and compared when execute consumes them.
module tb_decode_stage;
   import wisc_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic        id_ready;
   logic        flush;
   logic        wb_we;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic        ex_ready;
   logic        ex_valid;
   logic [15:0] ex_pc;
   logic [3:0]  ex_rd;
   logic [15:0] ex_op_a, ex_op_b, ex_imm;
   logic [3:0]  ex_alu_op;
   logic        ex_alu_src, ex_mem_rd, ex_mem_wr, ex_reg_we;
   logic [2:0]  ex_br_cond;
   logic        ex_branch, ex_call, ex_ret, ex_halt;

   logic [82:0] act_s;
   logic [82:0] q[$];
   int          checks = 0;
   int          errors = 0;

   decode_stage dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(id_ready), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
      .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rd(ex_rd), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
      .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_rd(ex_mem_rd),
      .ex_mem_wr(ex_mem_wr), .ex_reg_we(ex_reg_we), .ex_br_cond(ex_br_cond),
      .ex_branch(ex_branch), .ex_call(ex_call), .ex_ret(ex_ret), .ex_halt(ex_halt)
   );

   always #5 clk = ~clk;

   assign act_s = {ex_pc, ex_rd, ex_op_a, ex_op_b, ex_imm, ex_alu_op,
                   ex_alu_src, ex_mem_rd, ex_mem_wr, ex_reg_we, ex_br_cond,
                   ex_branch, ex_call, ex_ret, ex_halt};

   // ctl = {alu_src, mem_rd, mem_wr, reg_we}; fl = {branch, call, ret, halt}
   function automatic logic [82:0] ent(input logic [15:0] pc, input logic [3:0] rd,
                                       input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] imm, input logic [3:0] op,
                                       input logic [3:0] ctl, input logic [2:0] brc,
                                       input logic [3:0] fl);
      return {pc, rd, a, b, imm, op, ctl, brc, fl};
   endfunction

   task automatic chk(input string tag, input logic [82:0] obs, input logic [82:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic wb(input logic [3:0] a, input logic [15:0] d);
      wb_we = 1'b1;
      wb_addr = a;
      wb_data = d;
   endtask

   // one cycle: drive, check id_ready/ex_valid, run scoreboard, then clock
   task automatic step(input logic v, input logic [15:0] instr, input logic [15:0] pc,
                       input logic exr, input logic fl, input logic exp_rdy,
                       input int exp_v, input logic [82:0] exp_e, input string tag);
      logic [82:0] e;
      if_valid = v;
      if_instr = instr;
      if_pc = pc;
      ex_ready = exr;
      flush = fl;
      #1;
      chk({tag, ":id_ready"}, 83'(id_ready), 83'(exp_rdy));
      if (exp_v >= 0) chk({tag, ":ex_valid"}, 83'(ex_valid), (exp_v == 1) ? 83'd1 : 83'd0);
      if (ex_valid && ex_ready && !flush && !rst) begin
         chk({tag, ":sb_pending"}, 83'(q.size() != 0), 83'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk({tag, ":bundle"}, act_s, e);
         end
      end else if (ex_valid && flush && (q.size() != 0)) begin
         void'(q.pop_front());
      end
      if (rst) q.delete();
      if (v && exp_rdy && !fl && !rst) q.push_back(exp_e);
      @(posedge clk);
      #1;
      wb_we = 1'b0;
   endtask

   initial begin
      logic [82:0] z;
      z = 83'd0;
      rst = 1'b1;
      if_valid = 1'b0; if_instr = 16'h0000; if_pc = 16'h0000;
      flush = 1'b0; wb_we = 1'b0; wb_addr = 4'd0; wb_data = 16'h0000; ex_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("rst:bundle", act_s, z);
      chk("rst:ex_valid", 83'(ex_valid), 83'd0);
      chk("rst:id_ready", 83'(id_ready), 83'd0);
      rst = 1'b0;

      // basic R-type with operands written earlier
      wb(4'd1, 16'd5);
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 0, z, "wb1");
      wb(4'd2, 16'd7);
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 0, z, "wb2");
      step(1'b1, 16'h0312, 16'h0010, 1'b1, 1'b0, 1'b1, 0,
           ent(16'h0010, 4'd3, 16'd5, 16'd7, 16'd0, 4'h0, 4'b0001, 3'd0, 4'b0000), "add3");
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1, z, "add3_out");

      // load-use: one stall cycle, a bubble, then the dependent ADD
      step(1'b1, 16'h842F, 16'h0011, 1'b1, 1'b0, 1'b1, 0,
           ent(16'h0011, 4'd4, 16'd7, 16'd0, 16'hFFFF, 4'h8, 4'b1101, 3'd0, 4'b0000), "lw");
      step(1'b1, 16'h0541, 16'h0012, 1'b1, 1'b0, 1'b0, 1, z, "lu_stall");
      wb(4'd4, 16'h0044);
      step(1'b1, 16'h0541, 16'h0012, 1'b1, 1'b0, 1'b1, 0,
           ent(16'h0012, 4'd5, 16'h0044, 16'd5, 16'd0, 4'h0, 4'b0001, 3'd0, 4'b0000), "lu_bubble");
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1, z, "add5_out");

      // same-cycle writeback bypass
      wb(4'd6, 16'hBEEF);
      step(1'b1, 16'h0761, 16'h0013, 1'b1, 1'b0, 1'b1, 0,
           ent(16'h0013, 4'd7, 16'hBEEF, 16'd5, 16'd0, 4'h0, 4'b0001, 3'd0, 4'b0000), "bypass");

      // backpressure for three cycles
      step(1'b1, 16'h1961, 16'h0014, 1'b1, 1'b0, 1'b1, 1,
           ent(16'h0014, 4'd9, 16'hBEEF, 16'd5, 16'd0, 4'h1, 4'b0001, 3'd0, 4'b0000), "sub");
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 16'h4A13, 16'h0015, 1'b0, 1'b0, 1'b0, 1, z, "hold");
         chk("hold:pc", 83'(ex_pc), 83'h0014);
         chk("hold:op_a", 83'(ex_op_a), 83'hBEEF);
      end
      step(1'b1, 16'h4A13, 16'h0015, 1'b1, 1'b0, 1'b1, 1,
           ent(16'h0015, 4'd10, 16'd5, 16'd0, 16'd3, 4'h4, 4'b1001, 3'd0, 4'b0000), "release");
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1, z, "inc_out");

      // flush during a load-use stall under backpressure
      step(1'b1, 16'h842F, 16'h0016, 1'b1, 1'b0, 1'b1, 0,
           ent(16'h0016, 4'd4, 16'd7, 16'd0, 16'hFFFF, 4'h8, 4'b1101, 3'd0, 4'b0000), "lw2");
      step(1'b1, 16'h0541, 16'h0017, 1'b0, 1'b0, 1'b0, 1, z, "stall2");
      step(1'b1, 16'h0541, 16'h0017, 1'b0, 1'b1, 1'b0, 1, z, "flush_stall");
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 0, z, "post_flush");
      step(1'b1, 16'h0312, 16'h0020, 1'b1, 1'b1, 1'b1, 0, z, "flush_accept");
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 0, z, "flush_drop");

      // back-to-back issue of CALL, B, LHB, SW, ADD R0, HLT
      wb(4'd11, 16'h0F0F);
      step(1'b1, 16'hD800, 16'h0030, 1'b1, 1'b0, 1'b1, 0,
           ent(16'h0030, 4'(LINK_REG), 16'd0, 16'd0, 16'hF800, 4'hD, 4'b0001, 3'd0, 4'b0100), "call");
      step(1'b1, 16'hCFFE, 16'h0031, 1'b1, 1'b0, 1'b1, 1,
           ent(16'h0031, 4'd0, 16'd0, 16'd0, 16'hFFFE, 4'hC, 4'b0000, BR_UNCOND, 4'b1000), "br");
      step(1'b1, 16'hABAB, 16'h0032, 1'b1, 1'b0, 1'b1, 1,
           ent(16'h0032, 4'd11, 16'h0F0F, 16'd0, 16'h00AB, 4'hA, 4'b1001, 3'd0, 4'b0000), "lhb");
      step(1'b1, 16'h9612, 16'h0033, 1'b1, 1'b0, 1'b1, 1,
           ent(16'h0033, 4'd0, 16'd5, 16'hBEEF, 16'h0002, 4'h9, 4'b1010, 3'd0, 4'b0000), "sw");
      wb(4'd0, 16'hFFFF);
      step(1'b1, 16'h0300, 16'h0034, 1'b1, 1'b0, 1'b1, 1,
           ent(16'h0034, 4'd3, 16'd0, 16'd0, 16'd0, 4'h0, 4'b0001, 3'd0, 4'b0000), "r0");
      step(1'b1, 16'hF000, 16'h0040, 1'b1, 1'b0, 1'b1, 1,
           ent(16'h0040, 4'd0, 16'd0, 16'd0, 16'd0, 4'hF, 4'b0000, 3'd0, 4'b0001), "hlt");
      step(1'b1, 16'h0312, 16'h0041, 1'b1, 1'b0, 1'b0, 1, z, "halted");
      step(1'b1, 16'h0312, 16'h0041, 1'b1, 1'b1, 1'b0, 0, z, "halted_flush");
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 0, z, "halted_idle");

      // reset releases halt
      rst = 1'b1;
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, -1, z, "rst2");
      rst = 1'b0;
      chk("rst2:bundle", act_s, z);
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 0, z, "after_rst2");

      // reset in the middle of a stall discards the load and clears the registers
      step(1'b1, 16'h842F, 16'h0050, 1'b1, 1'b0, 1'b1, 0,
           ent(16'h0050, 4'd4, 16'd0, 16'd0, 16'hFFFF, 4'h8, 4'b1101, 3'd0, 4'b0000), "lw3");
      step(1'b1, 16'h0541, 16'h0051, 1'b0, 1'b0, 1'b0, 1, z, "stall3");
      rst = 1'b1;
      step(1'b1, 16'h0541, 16'h0051, 1'b0, 1'b0, 1'b0, 1, z, "rst_stall");
      rst = 1'b0;
      step(1'b1, 16'h0761, 16'h0052, 1'b1, 1'b0, 1'b1, 0,
           ent(16'h0052, 4'd7, 16'd0, 16'd0, 16'd0, 4'h0, 4'b0001, 3'd0, 4'b0000), "post_rst");
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1, z, "post_rst_out");

      chk("sb_drained", 83'(q.size()), 83'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
